// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet tracker: aligns to 3-byte stream packets, decodes buttons and
// deltas, and keeps a clamped absolute cursor with click/packet/sync strobes.
`timescale 1ns/1ps
module ps2_mouse_tracker #(
    parameter int unsigned X_MAX          = 639,
    parameter int unsigned Y_MAX          = 479,
    parameter int unsigned X_INIT         = 320,
    parameter int unsigned Y_INIT         = 240,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                         CLOCK_50,
    input  logic                         reset_n,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic [$clog2(X_MAX+1)-1:0]   cursor_x,
    output logic [$clog2(Y_MAX+1)-1:0]   cursor_y,
    output logic [2:0]                   buttons,
    output logic                         left_click,
    output logic                         packet_valid,
    output logic                         sync_error
);
    localparam int unsigned XW    = $clog2(X_MAX + 1);
    localparam int unsigned YW    = $clog2(Y_MAX + 1);
    localparam int unsigned AW    = 12;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {WAIT_B1, WAIT_B2, WAIT_B3, UPDATE} state_t;

    state_t            state, state_nxt;
    // Header byte minus the always-one bit 3: {y_ovf, x_ovf, y_sign, x_sign, M, R, L}
    logic [6:0]        hdr, hdr_nxt;
    logic [7:0]        byte2, byte2_nxt, byte3, byte3_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [XW-1:0]     cx_nxt;
    logic [YW-1:0]     cy_nxt;
    logic [2:0]        btn_nxt;
    logic              lc_nxt, pv_nxt, se_nxt;
    logic [8:0]        dx, dy;
    logic signed [AW-1:0] nx, ny;

    // State and all outputs registered together
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WAIT_B1;
            hdr          <= '0;
            byte2        <= '0;
            byte3        <= '0;
            cnt          <= '0;
            cursor_x     <= XW'(X_INIT);
            cursor_y     <= YW'(Y_INIT);
            buttons      <= '0;
            left_click   <= 1'b0;
            packet_valid <= 1'b0;
            sync_error   <= 1'b0;
        end else begin
            state        <= state_nxt;
            hdr          <= hdr_nxt;
            byte2        <= byte2_nxt;
            byte3        <= byte3_nxt;
            cnt          <= cnt_nxt;
            cursor_x     <= cx_nxt;
            cursor_y     <= cy_nxt;
            buttons      <= btn_nxt;
            left_click   <= lc_nxt;
            packet_valid <= pv_nxt;
            sync_error   <= se_nxt;
        end
    end

    // Next-state, packet decode and cursor arithmetic
    always_comb begin
        state_nxt = state;
        hdr_nxt   = hdr;
        byte2_nxt = byte2;
        byte3_nxt = byte3;
        cnt_nxt   = '0;
        cx_nxt    = cursor_x;
        cy_nxt    = cursor_y;
        btn_nxt   = buttons;
        lc_nxt    = 1'b0;
        pv_nxt    = 1'b0;
        se_nxt    = 1'b0;

        dx = hdr[5] ? 9'd0 : {hdr[3], byte2};
        dy = hdr[6] ? 9'd0 : {hdr[4], byte3};
        // PS/2 +Y is up while screen Y grows downward
        nx = AW'(cursor_x) + {{(AW-9){dx[8]}}, dx};
        ny = AW'(cursor_y) - {{(AW-9){dy[8]}}, dy};

        case (state)
            WAIT_B1, UPDATE: begin
                if (state == UPDATE) begin
                    if (nx[AW-1])                 cx_nxt = '0;
                    else if (nx > AW'(X_MAX))     cx_nxt = XW'(X_MAX);
                    else                          cx_nxt = XW'(nx);
                    if (ny[AW-1])                 cy_nxt = '0;
                    else if (ny > AW'(Y_MAX))     cy_nxt = YW'(Y_MAX);
                    else                          cy_nxt = YW'(ny);
                    btn_nxt = hdr[2:0];
                    lc_nxt  = hdr[0] & ~buttons[0];
                    pv_nxt  = 1'b1;
                end
                state_nxt = WAIT_B1;
                if (rx_valid) begin
                    if (rx_data[3]) begin
                        hdr_nxt   = {rx_data[7:4], rx_data[2:0]};
                        state_nxt = WAIT_B2;
                    end else begin
                        se_nxt = 1'b1;
                    end
                end
            end
            WAIT_B2, WAIT_B3: begin
                if (rx_valid) begin
                    if (state == WAIT_B2) begin
                        byte2_nxt = rx_data;
                        state_nxt = WAIT_B3;
                    end else begin
                        byte3_nxt = rx_data;
                        state_nxt = UPDATE;
                    end
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = WAIT_B1;
                    se_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = WAIT_B1;
        endcase
    end
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker: vector table of packets plus hand-written
// sequences for reset, resync, timeout, latency and back-to-back packets.
`timescale 1ns/1ps
module tb_ps2_mouse_tracker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [9:0] cursor_x;
    logic [8:0] cursor_y;
    logic [2:0] buttons;
    logic       left_click, packet_valid, sync_error;

    int n_checks = 0;
    int n_fail   = 0;
    int pv_cnt = 0, lc_cnt = 0, se_cnt = 0;

    ps2_mouse_tracker #(.TIMEOUT_CYCLES(100)) dut (
        .CLOCK_50    (clk),
        .reset_n     (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .buttons     (buttons),
        .left_click  (left_click),
        .packet_valid(packet_valid),
        .sync_error  (sync_error)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (packet_valid) pv_cnt++;
        if (left_click)   lc_cnt++;
        if (sync_error)   se_cnt++;
    end

    typedef struct {
        bit       rst;
        bit [7:0] b1, b2, b3;
        int       ex, ey, ebtn, epv, elc, ese;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Byte is sampled at the next posedge; returns 1 ns after that edge
    task automatic send_byte(input bit [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic send_pkt(input bit [7:0] b1, input bit [7:0] b2, input bit [7:0] b3);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int pv0, lc0, se0;
        //          rst  b1     b2     b3     x    y    btn pv lc se
        vecs[0]  = '{1, 8'h09, 8'h10, 8'h05, 336, 235, 1, 1, 1, 0};
        vecs[1]  = '{0, 8'h09, 8'h00, 8'h00, 336, 235, 1, 1, 0, 0};
        vecs[2]  = '{1, 8'h18, 8'h80, 8'h00, 192, 240, 0, 1, 0, 0};
        vecs[3]  = '{0, 8'h18, 8'h80, 8'h00,  64, 240, 0, 1, 0, 0};
        vecs[4]  = '{0, 8'h18, 8'h80, 8'h00,   0, 240, 0, 1, 0, 0};
        vecs[5]  = '{1, 8'h28, 8'h00, 8'h80, 320, 368, 0, 1, 0, 0};
        vecs[6]  = '{0, 8'h28, 8'h00, 8'h80, 320, 479, 0, 1, 0, 0};
        vecs[7]  = '{1, 8'h48, 8'hFF, 8'h02, 320, 238, 0, 1, 0, 0};
        vecs[8]  = '{0, 8'h08, 8'h01, 8'h01, 321, 237, 0, 1, 0, 0};
        vecs[9]  = '{0, 8'h0B, 8'h00, 8'h00, 321, 237, 3, 1, 1, 0};
        vecs[10] = '{0, 8'h0C, 8'h00, 8'h00, 321, 237, 4, 1, 0, 0};
        vecs[11] = '{0, 8'h0D, 8'h00, 8'h00, 321, 237, 5, 1, 1, 0};
        vecs[12] = '{0, 8'h08, 8'h00, 8'h7F, 321, 110, 0, 1, 0, 0};
        vecs[13] = '{0, 8'h18, 8'hFF, 8'hFF, 320,   0, 0, 1, 0, 0};
        vecs[14] = '{0, 8'h28, 8'h00, 8'h01, 320, 255, 0, 1, 0, 0};
        vecs[15] = '{0, 8'h08, 8'hFF, 8'h00, 575, 255, 0, 1, 0, 0};
        vecs[16] = '{0, 8'h08, 8'hFF, 8'h00, 639, 255, 0, 1, 0, 0};
        vecs[17] = '{0, 8'h88, 8'h01, 8'h80, 639, 255, 0, 1, 0, 0};

        // Reset values
        do_reset();
        check("reset_x", int'(cursor_x), 320);
        check("reset_y", int'(cursor_y), 240);
        check("reset_btn", int'(buttons), 0);
        check("reset_strobes", int'({left_click, packet_valid, sync_error}), 0);

        // Table-driven packets
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rst) do_reset();
            pv0 = pv_cnt; lc0 = lc_cnt; se0 = se_cnt;
            send_pkt(vecs[i].b1, vecs[i].b2, vecs[i].b3);
            idle(3);
            check($sformatf("v%0d_x", i), int'(cursor_x), vecs[i].ex);
            check($sformatf("v%0d_y", i), int'(cursor_y), vecs[i].ey);
            check($sformatf("v%0d_btn", i), int'(buttons), vecs[i].ebtn);
            check($sformatf("v%0d_pv", i), pv_cnt - pv0, vecs[i].epv);
            check($sformatf("v%0d_lc", i), lc_cnt - lc0, vecs[i].elc);
            check($sformatf("v%0d_se", i), se_cnt - se0, vecs[i].ese);
        end

        // Reset asserted mid-packet
        do_reset();
        send_byte(8'h08);
        send_byte(8'h05);
        pv0 = pv_cnt; lc0 = lc_cnt; se0 = se_cnt;
        rst_n = 1'b0;
        idle(3);
        check("midrst_x", int'(cursor_x), 320);
        check("midrst_y", int'(cursor_y), 240);
        check("midrst_btn", int'(buttons), 0);
        rst_n = 1'b1;
        idle(2);
        check("midrst_strobes", (pv_cnt - pv0) + (lc_cnt - lc0) + (se_cnt - se0), 0);
        send_pkt(8'h08, 8'h01, 8'h00);
        idle(3);
        check("midrst_pkt_x", int'(cursor_x), 321);
        check("midrst_pkt_y", int'(cursor_y), 240);
        check("midrst_pkt_pv", pv_cnt - pv0, 1);

        // Update latency: cursor and packet_valid appear one cycle after byte 3
        do_reset();
        send_byte(8'h09);
        send_byte(8'h10);
        send_byte(8'h05);
        check("lat_pv_early", int'(packet_valid), 0);
        check("lat_x_early", int'(cursor_x), 320);
        idle(1);
        check("lat_pv", int'(packet_valid), 1);
        check("lat_lc", int'(left_click), 1);
        check("lat_x", int'(cursor_x), 336);
        idle(1);
        check("lat_pv_single", int'(packet_valid), 0);

        // Resync on a byte with bit 3 clear
        do_reset();
        pv0 = pv_cnt; se0 = se_cnt;
        send_byte(8'h00);
        check("resync_se_now", int'(sync_error), 1);
        idle(1);
        check("resync_se_single", int'(sync_error), 0);
        send_pkt(8'h08, 8'h01, 8'h01);
        idle(3);
        check("resync_x", int'(cursor_x), 321);
        check("resync_y", int'(cursor_y), 239);
        check("resync_pv", pv_cnt - pv0, 1);
        check("resync_se", se_cnt - se0, 1);

        // Timeout of a partial packet
        do_reset();
        pv0 = pv_cnt; se0 = se_cnt;
        send_byte(8'h08);
        send_byte(8'h05);
        idle(110);
        check("tmo_se", se_cnt - se0, 1);
        check("tmo_pv", pv_cnt - pv0, 0);
        check("tmo_x", int'(cursor_x), 320);
        check("tmo_y", int'(cursor_y), 240);
        send_pkt(8'h08, 8'h02, 8'h00);
        idle(3);
        check("tmo_pkt_x", int'(cursor_x), 322);
        check("tmo_pkt_y", int'(cursor_y), 240);

        // Back-to-back packets: next byte 1 lands in the UPDATE cycle
        do_reset();
        pv0 = pv_cnt; se0 = se_cnt;
        send_pkt(8'h08, 8'h01, 8'h00);
        send_pkt(8'h08, 8'h01, 8'h00);
        idle(3);
        check("b2b_x", int'(cursor_x), 322);
        check("b2b_pv", pv_cnt - pv0, 2);
        check("b2b_se", se_cnt - se0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
